// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad scanning path.
// Row priority encoding lives here so other keypad consumers can reuse it.
package keypad_pkg;

    localparam int KEY_W = 4;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;

    localparam logic [COLS-1:0] COL_IDLE = 4'b1110;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_PRESSED,
        ST_RELEASE
    } scan_state_t;

    // Index of the lowest active-low row; the lowest index wins on ties.
    function automatic logic [1:0] low_row_index(input logic [ROWS-1:0] rows);
        logic [1:0] idx;
        idx = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (!rows[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: counts 0..DIV-1 and flags the wrap cycle with tick.
// Shared by the keypad scan and the FND refresh paths.
module tick_gen #(
    parameter int DIV = 1048576
) (
    input  logic clock_50m,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg + 1'b1;
        if (count_reg == CNT_LAST) begin
            count_next = '0;
        end
    end

    always_ff @(posedge clock_50m) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign tick = (count_reg == CNT_LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks the columns, debounces presses and releases,
// and reports each accepted key once as {row, col} with a one-cycle strobe.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1048576,
    parameter int DEBOUNCE_TICKS = 2
) (
    input  logic             clock_50m,
    input  logic             rst,
    input  logic [ROWS-1:0]  row_in,
    output logic [COLS-1:0]  col_out,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    output logic             key_held
);

    localparam int DB_W = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_TICKS);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

    logic              tick;

    logic [ROWS-1:0]   sync1_reg;
    logic [ROWS-1:0]   row_s_reg;

    scan_state_t       state_reg,    state_next;
    logic [1:0]        col_idx_reg,  col_idx_next;
    logic [COLS-1:0]   col_out_reg,  col_drive_next;
    logic [ROWS-1:0]   pattern_reg,  pattern_next;
    logic [DB_W-1:0]   db_cnt_reg,   db_cnt_next;
    logic [KEY_W-1:0]  key_code_reg, key_code_next;
    logic              key_valid_reg, key_valid_next;
    logic              key_held_reg,  key_held_next;

    logic              any_low;
    logic              all_high;
    logic [DB_W-1:0]   db_inc;

    tick_gen #(
        .DIV (SCAN_DIV)
    ) u_tick_gen (
        .clock_50m (clock_50m),
        .rst       (rst),
        .tick      (tick)
    );

    assign any_low  = ~&row_s_reg;
    assign all_high = &row_s_reg;
    assign db_inc   = db_cnt_reg + 1'b1;

    always_comb begin
        state_next     = state_reg;
        col_idx_next   = col_idx_reg;
        pattern_next   = pattern_reg;
        db_cnt_next    = db_cnt_reg;
        key_code_next  = key_code_reg;
        key_valid_next = 1'b0;
        key_held_next  = key_held_reg;

        if (tick) begin
            unique case (state_reg)
                ST_SCAN: begin
                    if (any_low) begin
                        pattern_next = row_s_reg;
                        db_cnt_next  = DB_ONE;
                        if (DEBOUNCE_TICKS == 1) begin
                            key_code_next  = {low_row_index(row_s_reg), col_idx_reg};
                            key_valid_next = 1'b1;
                            key_held_next  = 1'b1;
                            state_next     = ST_PRESSED;
                        end else begin
                            state_next = ST_DEBOUNCE;
                        end
                    end else begin
                        col_idx_next = col_idx_reg + 1'b1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (row_s_reg == pattern_reg) begin
                        db_cnt_next = db_inc;
                        if (db_inc == DB_LAST) begin
                            key_code_next  = {low_row_index(pattern_reg), col_idx_reg};
                            key_valid_next = 1'b1;
                            key_held_next  = 1'b1;
                            state_next     = ST_PRESSED;
                        end
                    end else begin
                        state_next   = ST_SCAN;
                        col_idx_next = col_idx_reg + 1'b1;
                    end
                end
                ST_PRESSED: begin
                    // Column stays frozen, so keys in other columns are invisible here.
                    if (all_high) begin
                        db_cnt_next = DB_ONE;
                        if (DEBOUNCE_TICKS == 1) begin
                            key_held_next = 1'b0;
                            state_next    = ST_SCAN;
                            col_idx_next  = col_idx_reg + 1'b1;
                        end else begin
                            state_next = ST_RELEASE;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (all_high) begin
                        db_cnt_next = db_inc;
                        if (db_inc == DB_LAST) begin
                            key_held_next = 1'b0;
                            state_next    = ST_SCAN;
                            col_idx_next  = col_idx_reg + 1'b1;
                        end
                    end else begin
                        state_next = ST_PRESSED;
                    end
                end
                default: begin
                    state_next = ST_SCAN;
                end
            endcase
        end
    end

    // Column drive is decoded from the next index so col_out itself is a register.
    for (genvar gi = 0; gi < COLS; gi++) begin : g_col_drive
        assign col_drive_next[gi] = (col_idx_next != 2'(gi));
    end

    always_ff @(posedge clock_50m) begin
        if (rst) begin
            sync1_reg     <= '1;
            row_s_reg     <= '1;
            state_reg     <= ST_SCAN;
            col_idx_reg   <= '0;
            col_out_reg   <= COL_IDLE;
            pattern_reg   <= '1;
            db_cnt_reg    <= '0;
            key_code_reg  <= '0;
            key_valid_reg <= 1'b0;
            key_held_reg  <= 1'b0;
        end else begin
            sync1_reg     <= row_in;
            row_s_reg     <= sync1_reg;
            state_reg     <= state_next;
            col_idx_reg   <= col_idx_next;
            col_out_reg   <= col_drive_next;
            pattern_reg   <= pattern_next;
            db_cnt_reg    <= db_cnt_next;
            key_code_reg  <= key_code_next;
            key_valid_reg <= key_valid_next;
            key_held_reg  <= key_held_next;
        end
    end

    assign col_out   = col_out_reg;
    assign key_code  = key_code_reg;
    assign key_valid = key_valid_reg;
    assign key_held  = key_held_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad model drives the rows, expected key
// codes go into a queue and a monitor pops one per key_valid strobe.
module tb_keypad_scanner;

    logic        clock_50m;
    logic        rst;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;

    logic [15:0] key_down;
    logic [3:0]  exp_q[$];
    int          errors;
    int          checks;

    keypad_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_TICKS (2)
    ) dut (
        .clock_50m (clock_50m),
        .rst       (rst),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clock_50m = 1'b0;
    always #5 clock_50m = ~clock_50m;

    // Key (r,c) pulls row r low while column c is driven low.
    always_comb begin
        row_in = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            row_in[r] = ~|(key_down[r*4 +: 4] & ~col_out);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clock_50m) begin
        if (key_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got code %0d, expected no strobe", key_code);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                check("key_code", 32'(key_code), 32'(e));
                check("held_with_valid", 32'(key_held), 32'd1);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clock_50m);
    endtask

    task automatic wait_col(input logic [3:0] target);
        int n;
        n = 0;
        while (col_out !== target && n < 100) begin
            @(negedge clock_50m);
            n++;
        end
        check("wait_col", 32'(col_out), 32'(target));
    endtask

    task automatic wait_release();
        int n;
        n = 0;
        while (key_held !== 1'b0 && n < 200) begin
            @(negedge clock_50m);
            n++;
        end
        check("release", 32'(key_held), 32'd0);
    endtask

    task automatic expect_consumed(input string name);
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        logic [3:0] exp_col;
        logic [3:0] mask;
        logic [1:0] c;
        logic [1:0] lo;
        logic [3:0] code;
        logic [15:0] keys;

        errors   = 0;
        checks   = 0;
        key_down = '0;
        rst      = 1'b1;
        repeat (3) @(posedge clock_50m);
        @(negedge clock_50m);
        check("rst_col", 32'(col_out), 32'hE);
        check("rst_code", 32'(key_code), 32'd0);
        check("rst_valid", 32'(key_valid), 32'd0);
        check("rst_held", 32'(key_held), 32'd0);
        rst = 1'b0;

        // Idle scan: one column step every 4 cycles.
        for (int s = 1; s <= 8; s++) begin
            repeat (4) @(posedge clock_50m);
            @(negedge clock_50m);
            exp_col = 4'b1111 & ~(4'b0001 << (s % 4));
            check("idle_col", 32'(col_out), 32'(exp_col));
            check("idle_held", 32'(key_held), 32'd0);
        end

        // Row 2 at column 1 held: single strobe, code 9, column frozen.
        wait_col(4'b1101);
        exp_q.push_back(4'd9);
        key_down[9] = 1'b1;
        cycles(60);
        expect_consumed("press9_seen");
        check("press9_held", 32'(key_held), 32'd1);
        check("press9_col", 32'(col_out), 32'hD);
        key_down = '0;
        wait_release();
        check("release_col", 32'(col_out), 32'hB);
        check("release_code", 32'(key_code), 32'd9);

        // Bounce: present on one tick, gone on the next; scan must move on.
        wait_col(4'b1101);
        key_down[9] = 1'b1;
        repeat (4) @(posedge clock_50m);
        @(negedge clock_50m);
        key_down = '0;
        repeat (4) @(posedge clock_50m);
        @(negedge clock_50m);
        check("bounce_col", 32'(col_out), 32'hB);
        key_down[9] = 1'b1;
        repeat (4) @(posedge clock_50m);
        @(negedge clock_50m);
        key_down = '0;
        cycles(20);
        check("bounce_held", 32'(key_held), 32'd0);

        // Rows 1 and 3 at column 0: lowest row wins.
        exp_q.push_back(4'd4);
        key_down[4]  = 1'b1;
        key_down[12] = 1'b1;
        cycles(60);
        expect_consumed("multirow_seen");
        key_down = '0;
        wait_release();
        cycles(8);

        // Reset while pressed.
        exp_q.push_back(4'd6);
        key_down[6] = 1'b1;
        cycles(60);
        expect_consumed("press6_seen");
        rst      = 1'b1;
        key_down = '0;
        @(posedge clock_50m);
        @(negedge clock_50m);
        rst = 1'b0;
        check("midrst_col", 32'(col_out), 32'hE);
        check("midrst_held", 32'(key_held), 32'd0);
        check("midrst_code", 32'(key_code), 32'd0);
        check("midrst_valid", 32'(key_valid), 32'd0);
        cycles(30);

        // Random presses within one column, with a stray key added while held.
        for (int t = 0; t < 20; t++) begin
            c    = 2'($urandom_range(0, 3));
            mask = 4'($urandom_range(1, 15));
            keys = '0;
            lo   = 2'd3;
            for (int r = 3; r >= 0; r--) begin
                if (mask[r]) begin
                    keys[r*4 + int'(c)] = 1'b1;
                    lo = 2'(r);
                end
            end
            code = {lo, c};
            exp_q.push_back(code);
            key_down = keys;
            cycles(30);
            if ($urandom_range(0, 1) == 1) begin
                key_down[$urandom_range(0, 15)] = 1'b1;
            end
            cycles(30);
            expect_consumed("rand_seen");
            check("rand_code_hold", 32'(key_code), 32'(code));
            key_down = '0;
            wait_release();
            cycles($urandom_range(4, 12));
        end

        cycles(20);
        expect_consumed("final_queue");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
